// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_DM = 2'd2
  } arb_state_e;

  localparam logic [31:0] ARB_ABORT_DATA = 32'h0;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch, load/store and memory-side signals of the shared bus; slave = arbiter view.
interface mem_bus_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_done;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_done;
  logic [31:0] dm_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_arb_timeout;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
           mem_addr, mem_wdata, mem_rd, mem_wr, mem_arb_timeout
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
           mem_addr, mem_wdata, mem_rd, mem_wr, mem_arb_timeout
  );

endinterface

// File: rtl/mem_bus_arbiter_wait_timer.sv
// Counts wait-state cycles of the access in flight; expired flags that this
// wait cycle is the TIMEOUT-th one, so the owner can abort on the same edge.
module mem_bus_arbiter_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Grants the single word-wide memory bus to fetch or load/store, one access at a time;
// gnt one cycle after the sampling edge, done one cycle after mem_ready or timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 15
) (
  input logic            mem_arb_clk,
  input logic            mem_arb_rst_n,
  mem_bus_arbiter_if.slave bus
);

  localparam int STREAK_W = (MAX_DM_STREAK > 0) ? $clog2(MAX_DM_STREAK + 1) : 1;

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic                if_done_q, if_done_d, dm_done_q, dm_done_d;
  logic                timeout_q, timeout_d;
  logic [31:0]         if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic [31:0]         mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic                mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic                dm_win, tmr_clr, tmr_en, tmr_expired;

  mem_bus_arbiter_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (mem_arb_clk),
    .rst_n   (mem_arb_rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // Streak cap only bites while IF is actually waiting.
  assign dm_win = bus.dm_req && (!bus.if_req || (MAX_DM_STREAK == 0) ||
                                 (streak_q < STREAK_W'(MAX_DM_STREAK)));

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    timeout_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (dm_win) begin
          dm_gnt_d    = 1'b1;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          mem_rd_d    = !bus.dm_we;
          mem_wr_d    = bus.dm_we;
          tmr_clr     = 1'b1;
          state_d     = ARB_BUSY_DM;
          if (streak_q < STREAK_W'(MAX_DM_STREAK)) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (bus.if_req) begin
          if_gnt_d   = 1'b1;
          mem_addr_d = bus.if_addr;
          mem_rd_d   = 1'b1;
          mem_wr_d   = 1'b0;
          tmr_clr    = 1'b1;
          streak_d   = '0;
          state_d    = ARB_BUSY_IF;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_DM: begin
        if (bus.mem_ready) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          state_d  = ARB_IDLE;
          if (state_q == ARB_BUSY_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            dm_done_d = 1'b1;
            if (!mem_wr_q) begin
              dm_rdata_d = bus.mem_rdata;
            end
          end
        end else if (tmr_expired) begin
          mem_rd_d  = 1'b0;
          mem_wr_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = ARB_IDLE;
          if (state_q == ARB_BUSY_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = ARB_ABORT_DATA;
          end else begin
            dm_done_d  = 1'b1;
            dm_rdata_d = ARB_ABORT_DATA;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge mem_arb_clk) begin
    if (!mem_arb_rst_n) begin
      state_q     <= ARB_IDLE;
      streak_q    <= '0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      timeout_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      timeout_q   <= timeout_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign bus.if_gnt          = if_gnt_q;
  assign bus.dm_gnt          = dm_gnt_q;
  assign bus.if_done         = if_done_q;
  assign bus.dm_done         = dm_done_q;
  assign bus.if_rdata        = if_rdata_q;
  assign bus.dm_rdata        = dm_rdata_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.mem_rd          = mem_rd_q;
  assign bus.mem_wr          = mem_wr_q;
  assign bus.mem_arb_timeout = timeout_q;

endmodule
